// File: rtl/wubsuit_apb_pwm_if.sv
// wubsuit_apb_pwm_if
// APB3 bus between the MSS fabric APB master and the PWM register block.
//
// Signals:
//   MSSPSEL     master -> completer  select
//   MSSPENABLE  master -> completer  access phase
//   MSSPWRITE   master -> completer  1 = write, 0 = read
//   MSSPADDR    master -> completer  byte address, bits [1:0] ignored
//   MSSPWDATA   master -> completer  write data
//   MSSPREADY   completer -> master  transfer complete
//   MSSPRDATA   completer -> master  read data, valid with MSSPREADY on a read
//   MSSPSLVERR  completer -> master  error response, valid with MSSPREADY
interface wubsuit_apb_pwm_if;
    logic        MSSPSEL;
    logic        MSSPENABLE;
    logic        MSSPWRITE;
    logic [7:0]  MSSPADDR;
    logic [31:0] MSSPWDATA;
    logic        MSSPREADY;
    logic [31:0] MSSPRDATA;
    logic        MSSPSLVERR;

    modport master (
        output MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
        input  MSSPREADY, MSSPRDATA, MSSPSLVERR
    );

    modport slave (
        input  MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
        output MSSPREADY, MSSPRDATA, MSSPSLVERR
    );
endinterface

// File: rtl/wubsuit_apb_pwm.sv
// wubsuit_apb_pwm
// APB3 completer holding the register file for the suit's vibration motors,
// plus the NUM_CH-channel PWM engine that drives them.
//
// Ports:
//   SYSCLK    fabric clock, all logic on the rising edge
//   SYSRESET  asynchronous active-high reset
//   apb       APB3 completer side (MSSP* signals)
//   PWM_OUT   motor drive, bit i = channel i, registered
//
// Register map (word offsets): 0x00 CTRL (bit0 EN), 0x04 PERIOD,
// 0x08+4*i DUTY_i, 0x3C STATUS (bit0 EN, [31:16] live counter).
// PERIOD/DUTY writes land in shadow registers. The engine copies shadows into
// its active registers only when the counter wraps (or every cycle while
// disabled), so a running waveform never glitches.
module wubsuit_apb_pwm #(
    parameter int          NUM_CH     = 8,
    parameter logic [15:0] RST_PERIOD = 16'hFFFF
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    wubsuit_apb_pwm_if.slave  apb,
    output logic [NUM_CH-1:0] PWM_OUT
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;  // setup seen, next cycle is first access
    localparam logic [1:0] ST_ACCESS = 2'd2;  // read wait state done, data registered

    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_PERIOD = 6'd1;
    localparam logic [5:0] W_DUTY0  = 6'd2;
    localparam logic [5:0] W_STATUS = 6'd15;
    localparam logic [5:0] DUTY_END = 6'(2 + NUM_CH);

    logic [1:0]  state;
    logic        en;
    logic [15:0] cnt;
    logic [15:0] period_sh;
    logic [15:0] period_act;
    logic [15:0] duty_sh  [NUM_CH];
    logic [15:0] duty_act [NUM_CH];
    logic [31:0] rdata_q;

    logic [5:0]  word;
    logic        access;
    logic        is_duty;
    logic        addr_ok;
    logic        ready;
    logic        wr_fire;
    logic        wrap;
    logic [31:0] rd_mux;
    logic        unused_apb_bits;

    assign word    = apb.MSSPADDR[7:2];
    assign access  = apb.MSSPSEL && apb.MSSPENABLE;
    assign is_duty = (word >= W_DUTY0) && (word < DUTY_END);
    // STATUS is read-only: a write there is an error like an unmapped address.
    assign addr_ok = (word == W_CTRL) || (word == W_PERIOD) || is_duty ||
                     ((word == W_STATUS) && !apb.MSSPWRITE);

    // Writes finish in the first access cycle; reads need the extra cycle
    // spent in ST_ACCESS because read data is registered.
    assign ready   = access && (((state == ST_SETUP) && apb.MSSPWRITE) ||
                                (state == ST_ACCESS));
    assign wr_fire = access && (state == ST_SETUP) && apb.MSSPWRITE && addr_ok;

    assign apb.MSSPREADY  = ready;
    assign apb.MSSPSLVERR = ready && !addr_ok;
    assign apb.MSSPRDATA  = rdata_q;

    assign unused_apb_bits = ^{apb.MSSPWDATA[31:16], apb.MSSPADDR[1:0]};

    // Read mux returns shadow values; unmapped words fall through as 0.
    always_comb begin
        rd_mux = '0;
        if (word == W_CTRL)
            rd_mux[0] = en;
        else if (word == W_PERIOD)
            rd_mux[15:0] = period_sh;
        else if (word == W_STATUS)
            rd_mux = {cnt, 15'd0, en};
        for (int i = 0; i < NUM_CH; i++)
            if (word == 6'(W_DUTY0 + i))
                rd_mux[15:0] = duty_sh[i];
    end

    // APB state machine and registered read data
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            rdata_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (apb.MSSPSEL && !apb.MSSPENABLE)
                        state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!apb.MSSPSEL) begin
                        state <= ST_IDLE;
                    end else if (apb.MSSPENABLE) begin
                        if (apb.MSSPWRITE) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_ACCESS;
                            rdata_q <= rd_mux;
                        end
                    end
                end
                // Completing read cycle, or the master gave up: either way
                // the transfer is over.
                ST_ACCESS: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign wrap = en && (cnt == period_act);

    // PWM engine and register file
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            en         <= 1'b0;
            cnt        <= '0;
            period_sh  <= RST_PERIOD;
            period_act <= RST_PERIOD;
            PWM_OUT    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            // Active registers take the pre-edge shadows, so a shadow write on
            // the wrap edge only shows up at the following wrap.
            if (!en || wrap) begin
                cnt        <= '0;
                period_act <= period_sh;
                for (int i = 0; i < NUM_CH; i++)
                    duty_act[i] <= duty_sh[i];
            end else begin
                cnt <= cnt + 16'd1;
            end

            for (int i = 0; i < NUM_CH; i++)
                PWM_OUT[i] <= en && (cnt < duty_act[i]);

            if (wr_fire) begin
                if (word == W_CTRL)
                    en <= apb.MSSPWDATA[0];
                if (word == W_PERIOD)
                    period_sh <= apb.MSSPWDATA[15:0];
                for (int i = 0; i < NUM_CH; i++)
                    if (word == 6'(W_DUTY0 + i))
                        duty_sh[i] <= apb.MSSPWDATA[15:0];
            end
        end
    end

endmodule

// File: tb/tb_wubsuit_apb_pwm.sv
// tb_wubsuit_apb_pwm
// Self-checking bench for wubsuit_apb_pwm: directed APB/PWM scenarios followed
// by randomized register traffic, with PWM_OUT compared every cycle against a
// behavioural model of the motor waveform.
`timescale 1ns/1ps
module tb_wubsuit_apb_pwm;

    localparam int NUM_CH = 8;

    logic              SYSCLK = 1'b0;
    logic              SYSRESET = 1'b1;
    logic [NUM_CH-1:0] PWM_OUT;

    wubsuit_apb_pwm_if bus();

    wubsuit_apb_pwm #(
        .NUM_CH     (NUM_CH),
        .RST_PERIOD (16'hFFFF)
    ) dut (
        .SYSCLK   (SYSCLK),
        .SYSRESET (SYSRESET),
        .apb      (bus),
        .PWM_OUT  (PWM_OUT)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: waveform position within the period, shadow and
    // active settings, and the expected output bits.
    int                m_en;
    int                m_cnt;
    int                m_psh;
    int                m_pact;
    int                m_dsh  [NUM_CH];
    int                m_dact [NUM_CH];
    logic [NUM_CH-1:0] m_pwm;
    bit                m_after_setup;
    bit                mon_on = 1'b0;

    function automatic bit addr_ok(input logic [7:0] a, input bit wr);
        int w;
        w = int'(a[7:2]);
        return (w <= 1) || (w >= 2 && w < 2 + NUM_CH) || (w == 15 && !wr);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int w;
        logic [31:0] r;
        w = int'(a[7:2]);
        r = '0;
        if (w == 0)
            r = 32'(m_en);
        else if (w == 1)
            r = 32'(m_psh);
        else if (w == 15)
            r = (32'(m_cnt) << 16) | 32'(m_en);
        for (int i = 0; i < NUM_CH; i++)
            if (w == 2 + i)
                r = 32'(m_dsh[i]);
        return r;
    endfunction

    always @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            m_en          <= 0;
            m_cnt         <= 0;
            m_psh         <= 65535;
            m_pact        <= 65535;
            m_pwm         <= '0;
            m_after_setup <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_dsh[i]  <= 0;
                m_dact[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                m_pwm[i] <= (m_en != 0) && (m_cnt < m_dact[i]);
            if (m_en == 0 || m_cnt == m_pact) begin
                m_cnt  <= 0;
                m_pact <= m_psh;
                for (int i = 0; i < NUM_CH; i++)
                    m_dact[i] <= m_dsh[i];
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (bus.MSSPSEL && bus.MSSPENABLE && bus.MSSPWRITE && m_after_setup &&
                addr_ok(bus.MSSPADDR, 1'b1)) begin
                if (bus.MSSPADDR[7:2] == 6'd0)
                    m_en <= int'(bus.MSSPWDATA[0]);
                if (bus.MSSPADDR[7:2] == 6'd1)
                    m_psh <= int'(bus.MSSPWDATA[15:0]);
                for (int i = 0; i < NUM_CH; i++)
                    if (bus.MSSPADDR[7:2] == 6'(2 + i))
                        m_dsh[i] <= int'(bus.MSSPWDATA[15:0]);
            end
            m_after_setup <= bus.MSSPSEL && !bus.MSSPENABLE;
        end
    end

    always @(negedge SYSCLK)
        if (mon_on)
            chk("pwm_out", 32'(PWM_OUT), 32'(m_pwm));

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, input string tag);
        logic exp_e;
        exp_e = !addr_ok(addr, 1'b1);
        @(posedge SYSCLK); #1;
        bus.MSSPSEL    = 1'b1;
        bus.MSSPENABLE = 1'b0;
        bus.MSSPWRITE  = 1'b1;
        bus.MSSPADDR   = addr;
        bus.MSSPWDATA  = data;
        @(posedge SYSCLK); #1;
        bus.MSSPENABLE = 1'b1;
        @(negedge SYSCLK);
        chk({tag, "_rdy"}, 32'(bus.MSSPREADY), 32'd1);
        chk({tag, "_err"}, 32'(bus.MSSPSLVERR), 32'(exp_e));
        @(posedge SYSCLK); #1;
        bus.MSSPSEL    = 1'b0;
        bus.MSSPENABLE = 1'b0;
    endtask

    task automatic apb_read_chk(input logic [7:0] addr, input string tag);
        logic [31:0] exp_d;
        logic        exp_e;
        int          waits;
        bit          done;
        @(posedge SYSCLK); #1;
        bus.MSSPSEL    = 1'b1;
        bus.MSSPENABLE = 1'b0;
        bus.MSSPWRITE  = 1'b0;
        bus.MSSPADDR   = addr;
        bus.MSSPWDATA  = '0;
        @(posedge SYSCLK); #1;
        bus.MSSPENABLE = 1'b1;
        // Register contents seen during the first access cycle are what the
        // completer captures at its end.
        exp_d = exp_read(addr);
        exp_e = !addr_ok(addr, 1'b0);
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge SYSCLK);
            if (bus.MSSPREADY) begin
                done = 1'b1;
            end else begin
                waits++;
                @(posedge SYSCLK); #1;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_waits"}, 32'(waits), 32'd1);
        chk({tag, "_data"}, bus.MSSPRDATA, exp_d);
        chk({tag, "_err"}, 32'(bus.MSSPSLVERR), 32'(exp_e));
        @(posedge SYSCLK); #1;
        bus.MSSPSEL    = 1'b0;
        bus.MSSPENABLE = 1'b0;
        @(negedge SYSCLK);
        chk({tag, "_rdclr"}, bus.MSSPRDATA, 32'd0);
    endtask

    task automatic wait_cnt(input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge SYSCLK);
            if (m_cnt == target)
                hit = 1'b1;
        end
        chk({tag, "_sync"}, 32'(hit), 32'd1);
    endtask

    // High cycles of channels 0..2 over the next n samples.
    task automatic measure(input int n, output int h0, output int h1, output int h2);
        h0 = 0;
        h1 = 0;
        h2 = 0;
        repeat (n) begin
            @(negedge SYSCLK);
            h0 += int'(PWM_OUT[0]);
            h1 += int'(PWM_OUT[1]);
            h2 += int'(PWM_OUT[2]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0, h1, h2;
        int op;
        int ch;
        int k;
        logic [7:0] a;

        bus.MSSPSEL    = 1'b0;
        bus.MSSPENABLE = 1'b0;
        bus.MSSPWRITE  = 1'b0;
        bus.MSSPADDR   = '0;
        bus.MSSPWDATA  = '0;
        SYSRESET       = 1'b1;
        repeat (3) @(posedge SYSCLK);
        #1;
        chk("rst_pwm", 32'(PWM_OUT), 32'd0);
        chk("rst_rdy", 32'(bus.MSSPREADY), 32'd0);
        chk("rst_rdata", bus.MSSPRDATA, 32'd0);
        chk("rst_slverr", 32'(bus.MSSPSLVERR), 32'd0);
        SYSRESET = 1'b0;
        mon_on   = 1'b1;

        apb_read_chk(8'h04, "rd_period_rst");
        apb_read_chk(8'h08, "rd_duty0_rst");
        apb_read_chk(8'h3C, "rd_status_rst");

        // Basic waveform: period 10 counts
        apb_write(8'h04, 32'd9, "wr_period");
        apb_write(8'h08, 32'd3, "wr_duty0");
        apb_write(8'h0C, 32'd0, "wr_duty1");
        apb_write(8'h10, 32'd12, "wr_duty2");
        apb_write(8'h00, 32'd1, "wr_ctrl");
        wait_cnt(0, "basic");
        measure(10, h0, h1, h2);
        chk("basic_ch0_high", 32'(h0), 32'd3);
        chk("basic_ch1_low", 32'(h1), 32'd0);
        chk("basic_ch2_high", 32'(h2), 32'd10);

        // Mid-period duty change must not cut the running period short
        wait_cnt(1, "mid");
        apb_write(8'h08, 32'd7, "wr_duty0_mid");
        measure(5, h0, h1, h2);
        chk("mid_no_runt", 32'(h0), 32'd0);
        wait_cnt(0, "mid_wrap");
        measure(10, h0, h1, h2);
        chk("mid_new_duty", 32'(h0), 32'd7);

        // Error responses
        apb_write(8'h3C, 32'hDEAD_BEEF, "wr_status");
        apb_read_chk(8'h40, "rd_unmapped");
        apb_read_chk(8'h3C, "rd_status_run");
        apb_read_chk(8'h00, "rd_ctrl_run");

        // Shadow write landing exactly on the wrap edge
        apb_write(8'h08, 32'd3, "wr_duty0_back");
        repeat (25) @(posedge SYSCLK);
        wait_cnt(7, "wrapedge");
        apb_write(8'h08, 32'd5, "wr_duty0_wrap");
        wait_cnt(0, "wrapedge_start");
        measure(10, h0, h1, h2);
        chk("wrap_old_duty", 32'(h0), 32'd3);
        measure(10, h0, h1, h2);
        chk("wrap_new_duty", 32'(h0), 32'd5);

        // Randomized register traffic
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3) begin
                ch = int'($urandom_range(0, NUM_CH - 1));
                apb_write(8'((2 + ch) * 4), 32'($urandom_range(0, 20)), "rnd_wr_duty");
            end else if (op == 4) begin
                apb_write(8'h04, 32'($urandom_range(3, 15)), "rnd_wr_period");
            end else if (op == 5) begin
                apb_write(8'h00, 32'($urandom_range(0, 3) != 0), "rnd_wr_ctrl");
            end else if (op <= 7) begin
                k = int'($urandom_range(0, NUM_CH + 2));
                if (k == NUM_CH + 2)
                    k = 15;
                a = 8'(k * 4 + int'($urandom_range(0, 3)));
                apb_read_chk(a, "rnd_rd");
            end else if (op == 8) begin
                a = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1)
                    apb_read_chk(a, "rnd_rd_any");
                else
                    apb_write(a, 32'($urandom_range(0, 20)), "rnd_wr_any");
            end else begin
                repeat ($urandom_range(0, 15)) @(posedge SYSCLK);
            end
        end

        // Reset in the middle of a read wait state while running
        apb_write(8'h04, 32'd9, "pre_rst_period");
        apb_write(8'h10, 32'd12, "pre_rst_duty2");
        apb_write(8'h00, 32'd1, "pre_rst_ctrl");
        repeat (5) @(posedge SYSCLK);
        @(negedge SYSCLK);
        chk("pre_rst_pwm2", 32'(PWM_OUT[2]), 32'd1);
        @(posedge SYSCLK); #1;
        bus.MSSPSEL    = 1'b1;
        bus.MSSPENABLE = 1'b0;
        bus.MSSPWRITE  = 1'b0;
        bus.MSSPADDR   = 8'h08;
        @(posedge SYSCLK); #1;
        bus.MSSPENABLE = 1'b1;
        @(negedge SYSCLK);
        chk("rst_wait_rdy", 32'(bus.MSSPREADY), 32'd0);
        #1;
        SYSRESET = 1'b1;
        #1;
        chk("rst_mid_pwm", 32'(PWM_OUT), 32'd0);
        chk("rst_mid_rdy", 32'(bus.MSSPREADY), 32'd0);
        chk("rst_mid_rdata", bus.MSSPRDATA, 32'd0);
        @(posedge SYSCLK); #1;
        chk("rst_hold_rdy", 32'(bus.MSSPREADY), 32'd0);
        bus.MSSPSEL    = 1'b0;
        bus.MSSPENABLE = 1'b0;
        repeat (2) @(posedge SYSCLK);
        #1;
        SYSRESET = 1'b0;
        apb_read_chk(8'h00, "post_rst_ctrl");
        apb_read_chk(8'h04, "post_rst_period");
        apb_read_chk(8'h08, "post_rst_duty0");
        apb_read_chk(8'h10, "post_rst_duty2");
        apb_read_chk(8'h3C, "post_rst_status");

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wubsuit_apb_pwm.md
# wubsuit_apb_pwm

APB3 completer in the fabric that terminates the MSS's fabric APB master (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA in, MSSPREADY/MSSPRDATA/MSSPSLVERR out). It holds a small register file and drives NUM_CH PWM outputs for the suit's vibration motors. Duty and period writes are double-buffered and applied only at PWM period wrap, so motor waveforms never glitch.

## Interface
- NUM_CH, 8: number of PWM channels, 1..12.
- RST_PERIOD, 16'hFFFF: reset value of PERIOD.
- SYSCLK  in  1  fabric clock (FAB_CLK from MSS); all logic on rising edge.
- SYSRESET  in  1  asynchronous, active-high reset.
- MSSPSEL  in  1  APB select.
- MSSPENABLE  in  1  APB access phase.
- MSSPWRITE  in  1  1 = write, 0 = read.
- MSSPADDR  in  8  byte address; bits [1:0] ignored.
- MSSPWDATA  in  32  write data.
- MSSPREADY  out  1  transfer complete.
- MSSPRDATA  out  32  read data, valid when MSSPREADY=1 on a read.
- MSSPSLVERR  out  1  error response, valid only with MSSPREADY=1.
- PWM_OUT  out  NUM_CH  motor drive, bit i = channel i.

## Operation
- Register map (word offsets):
  - 0x00 CTRL RW: bit0 EN; other bits read 0.
  - 0x04 PERIOD RW: [15:0] shadow period; PWM cycle is PERIOD+1 counts.
  - 0x08+4*i DUTY_i RW, i < NUM_CH: [15:0] shadow duty.
  - 0x3C STATUS RO: bit0 = EN, [31:16] = live counter value.
  - Any other address, or any write to 0x3C: SLVERR; no register changes; read data 0.
- Reads return shadow values, not active values; unused bits read 0.
- PWM engine: 16-bit counter CNT counts 0..PERIOD_ACT, wraps to 0.
  - PWM_OUT[i] = EN && (CNT < DUTY_ACT[i]) (registered, one cycle after CNT).
  - DUTY=0 -> constant low; DUTY > PERIOD -> constant high.
  - On the edge where CNT wraps (CNT==PERIOD_ACT), PERIOD_ACT and all DUTY_ACT load from shadows.
- EN=0: CNT held at 0, PWM_OUT all 0, active registers track shadows every cycle (immediate update).
- EN 0->1: counting starts from CNT=0 on the following edge with current shadows.
- APB state machine: IDLE -> SETUP (MSSPSEL=1, MSSPENABLE=0) -> ACCESS (MSSPENABLE=1).
  - Write: zero wait states; MSSPREADY=1 in the first ACCESS cycle; register updates on that edge.
  - Read: one wait state; first ACCESS cycle MSSPREADY=0 and read data is registered; second ACCESS cycle MSSPREADY=1 with MSSPRDATA valid.
  - MSSPSEL dropped mid-transfer: return to IDLE; no register update; wait-state flag cleared.
- Simultaneous wrap and shadow write on the same edge: active loads the pre-edge shadow value; the new value applies at the following wrap.
- PERIOD shadow written below current CNT: no effect until wrap; CNT keeps counting to PERIOD_ACT.

## Timing
- Reset (asynchronous): MSSPREADY=0, MSSPRDATA=0, MSSPSLVERR=0, PWM_OUT=0, EN=0, CNT=0, PERIOD shadow/active=RST_PERIOD, all DUTY=0, APB FSM=IDLE.
- MSSPREADY, MSSPSLVERR: combinational from FSM state and access-phase decode; 0 outside ACCESS.
- MSSPRDATA: registered; 0 except in the completing read cycle.
- Write-to-PWM latency with EN=1: takes effect at the next wrap plus one cycle (output register).
- Write-to-PWM latency with EN=0: active registers update one cycle after the write edge.
- Reset asserted mid-transfer: abort immediately; master sees MSSPREADY=0 until reset release.

## Test plan
- Reset, then read 0x04, 0x08, 0x3C -> 0x0000FFFF, 0, 0; each read shows exactly one MSSPREADY=0 wait cycle; MSSPSLVERR=0.
- Write PERIOD=9, DUTY_0=3, DUTY_1=0, DUTY_2=12, then CTRL=1 -> PWM_OUT[0] high 3 of every 10 cycles; [1] constant 0; [2] constant 1; writes complete with MSSPREADY=1 in the first ACCESS cycle.
- While running, write DUTY_0=7 mid-period -> current period keeps 3-high; the next period after wrap is 7-high; no runt pulse.
- Write to 0x3C and read 0x40 -> MSSPSLVERR=1 with MSSPREADY=1; STATUS unchanged; read data 0.
- Issue DUTY_0=5 on the exact wrap edge with the old shadow at 3 -> one further period at 3, then 5.
- Assert SYSRESET during a read wait state with EN=1 -> PWM_OUT=0 and MSSPREADY=0 immediately; after release, registers read their reset values.
